cos_sched: RTL and testbench

COS_SCHED -- requirements
Module: cos_sched

---
 rtl/cos_sched_pkg.sv | 21 ++
 rtl/cos_sched_if.sv | 39 +++
 rtl/cos_sched_rr_arbiter.sv | 37 +++
 rtl/cos_sched.sv | 176 +++++++++++++++++
 tb/tb_cos_sched.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cos_sched_pkg.sv
// cos_sched_pkg -- shared types and constants for the cosine-core scheduler.
//   state_t   : scheduler FSM states
//   W_DEFAULT : default angle/result width
//   FXP_SHIFT : fractional bits of the angle/result fixed-point format
//   ONE_FXP   : 1.0 in that format
package cos_sched_pkg;

  localparam int W_DEFAULT = 24;
  localparam int FXP_SHIFT = 10;
  localparam int ONE_FXP   = 1 << FXP_SHIFT;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LO,
    WAIT_HI,
    DONE,
    RELEASE
  } state_t;

endpackage

// File: rtl/cos_sched_if.sv
// cos_sched_if -- requester and cosine-core signals of the scheduler.
//   req_valid  [N_REQ]   request per requester, held with its angle until accepted
//   req_angle  [N_REQ*W] packed angles, requester i at [i*W +: W]
//   req_ready  [N_REQ]   one-hot acceptance pulse
//   rsp_valid  [N_REQ]   one-hot response pulse
//   rsp_cos    [W]       shared result bus
//   core_start           level start to the cosine core
//   core_angle [W]       angle presented to the core
//   core_ready           core done flag (sticky until the next start)
//   core_cos   [W]       core result
// Modports: master = scheduler side, slave = requesters + core side.
interface cos_sched_if
  import cos_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = W_DEFAULT
) ();

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_angle;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W-1:0]       rsp_cos;
  logic               core_start;
  logic [W-1:0]       core_angle;
  logic               core_ready;
  logic [W-1:0]       core_cos;

  modport master (
    input  req_valid, req_angle, core_ready, core_cos,
    output req_ready, rsp_valid, rsp_cos, core_start, core_angle
  );

  modport slave (
    output req_valid, req_angle, core_ready, core_cos,
    input  req_ready, rsp_valid, rsp_cos, core_start, core_angle
  );

endinterface

// File: rtl/cos_sched_rr_arbiter.sv
// rr_arbiter -- combinational round-robin arbiter.
//   req   [N_REQ] request vector
//   ptr   [PW]    index where the search starts
//   grant [N_REQ] one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant
);

  localparam int PW1 = PW + 1;

  logic [PW1-1:0] sum;
  logic [PW-1:0]  idx;
  logic           found;

  // Walk the requesters starting at ptr, wrapping modulo N_REQ; first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + PW1'(i);
      if (sum >= PW1'(N_REQ)) sum = sum - PW1'(N_REQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cos_sched.sv
// cos_sched -- shares one cosine core among N_REQ requesters, one operation
// at a time, with round-robin arbitration. Angles and results are passed
// through untouched.
//   clock, reset : single clock, synchronous active-high reset
//   bus          : cos_sched_if.master (requester handshake + core handshake)
//   busy         : high in every state except IDLE
//   err          : (only with COS_SCHED_TIMEOUT_EN) pulses with rsp_valid when
//                  the core did not answer within TIMEOUT wait cycles
// Optional feature macro: COS_SCHED_TIMEOUT_EN (watchdog + err port).
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a request; grant, latch angle on any req_valid
// START   | first cycle of core_start
// WAIT_LO | core_start held; wait for the previous sticky ready to clear
// WAIT_HI | core_start held; wait for core_ready
// DONE    | rsp_valid pulse to the granted requester, core_start low
// RELEASE | one more core_start-low cycle so the core returns to idle
module cos_sched
  import cos_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = W_DEFAULT,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  cos_sched_if.master bus,
  output logic        busy
`ifdef COS_SCHED_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || W <= FXP_SHIFT || TIMEOUT < 1) begin : g_param_chk
    $error("cos_sched: parameter out of range");
  end

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, g_idx, next_ptr;
  logic [N_REQ-1:0] grant, g_q, g_d, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     sel_angle, angle_q, angle_d, cos_q, cos_d;

`ifdef COS_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           wd_tc;
  logic           err_q, err_d;
  assign wd_tc = (wd_q == '0);
`endif

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    g_idx     = '0;
    sel_angle = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        g_idx     = PW'(i);
        sel_angle = bus.req_angle[i*W +: W];
      end
    end
  end

  assign next_ptr = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + PW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      angle_q     <= '0;
      cos_q       <= '0;
      rsp_valid_q <= '0;
`ifdef COS_SCHED_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      angle_q     <= angle_d;
      cos_q       <= cos_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef COS_SCHED_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  // rsp_valid/err are registered on the transition into DONE, so they are
  // high exactly while the FSM sits in DONE, aligned with the new rsp_cos.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    angle_d     = angle_q;
    cos_d       = cos_q;
    rsp_valid_d = '0;
    req_ready_d = '0;
`ifdef COS_SCHED_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // No acceptance is signalled while reset is asserted: the latch
        // below would be discarded anyway.
        if (|bus.req_valid && !reset) begin
          req_ready_d = grant;
          g_d         = grant;
          angle_d     = sel_angle;
          ptr_d       = next_ptr;
          state_d     = START;
`ifdef COS_SCHED_TIMEOUT_EN
          wd_d        = WDW'(TIMEOUT - 1);
`endif
        end
      end
      START: state_d = WAIT_LO;
      WAIT_LO: begin
`ifdef COS_SCHED_TIMEOUT_EN
        wd_d = wd_q - 1'b1;
        if (wd_tc) begin
          state_d     = DONE;
          cos_d       = '0;
          rsp_valid_d = g_q;
          err_d       = 1'b1;
        end else
`endif
        if (!bus.core_ready) state_d = WAIT_HI;
      end
      WAIT_HI: begin
`ifdef COS_SCHED_TIMEOUT_EN
        wd_d = wd_q - 1'b1;
`endif
        if (bus.core_ready) begin
          state_d     = DONE;
          cos_d       = bus.core_cos;
          rsp_valid_d = g_q;
        end
`ifdef COS_SCHED_TIMEOUT_EN
        else if (wd_tc) begin
          state_d     = DONE;
          cos_d       = '0;
          rsp_valid_d = g_q;
          err_d       = 1'b1;
        end
`endif
      end
      DONE:    state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = req_ready_d;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_cos    = cos_q;
  assign bus.core_angle = angle_q;
  assign bus.core_start = (state_q == START) || (state_q == WAIT_LO) || (state_q == WAIT_HI);
  assign busy           = (state_q != IDLE);
`ifdef COS_SCHED_TIMEOUT_EN
  assign err            = err_q;
`endif

endmodule

// File: tb/tb_cos_sched.sv
// tb_cos_sched -- scoreboard bench for cos_sched with a cycle model of the
// cosine core (Bhaskara approximation, fixed latency, sticky ready that clears
// one cycle after a rising start).
module tb_cos_sched;
  import cos_sched_pkg::*;

  localparam int N        = 4;
  localparam int WD       = 24;
  localparam int TO       = 64;
  localparam int CORE_LAT = 5;
  localparam longint PI2  = 10106;  // pi^2 in Q10

  typedef struct {
    int           idx;
    logic [WD-1:0] cos;
    logic         err;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic busy;
`ifdef COS_SCHED_TIMEOUT_EN
  logic err;
`endif

  always #5 clock = ~clock;

  cos_sched_if #(.N_REQ(N), .W(WD)) bus ();

  cos_sched #(.N_REQ(N), .W(WD), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
`ifdef COS_SCHED_TIMEOUT_EN
    ,
    .err   (err)
`endif
  );

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WD-1:0] cos_ref(input logic [WD-1:0] a);
    longint x, x2, num, den;
    x   = longint'($signed(a));
    x2  = (x * x) >>> FXP_SHIFT;
    num = PI2 - 4 * x2;
    den = PI2 + x2;
    return WD'((num <<< FXP_SHIFT) / den);
  endfunction

  // ---------------- cosine core model ----------------
  logic          start_q, start_qq, core_run;
  int            core_cnt;
  logic [WD-1:0] core_ang;
  bit            core_dead = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      start_q        <= 1'b0;
      start_qq       <= 1'b0;
      core_run       <= 1'b0;
      core_cnt       <= 0;
      bus.core_ready <= 1'b0;
      bus.core_cos   <= '0;
    end else begin
      start_q  <= bus.core_start;
      start_qq <= start_q;
      if (start_q && !start_qq) begin
        core_run       <= 1'b1;
        core_cnt       <= CORE_LAT;
        core_ang       <= bus.core_angle;
        bus.core_ready <= 1'b0;
      end else if (core_run) begin
        if (core_cnt == 1) begin
          core_run       <= 1'b0;
          bus.core_ready <= !core_dead;
          bus.core_cos   <= cos_ref(core_ang);
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int   ready_cnt[N];
  int   rsp_cnt[N];
  int   start_cycles = 0;
  int   busy_viol = 0;
  exp_t mon_e;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.core_start) start_cycles++;
      if (busy && |bus.req_ready) busy_viol++;
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i]) ready_cnt[i]++;
        if (bus.rsp_valid[i]) rsp_cnt[i]++;
      end
      if (|bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_who", bus.rsp_valid, 1 << mon_e.idx);
          chk("rsp_cos", bus.rsp_cos, mon_e.cos);
`ifdef COS_SCHED_TIMEOUT_EN
          chk("rsp_err", err, mon_e.err);
`endif
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit hold[N];

  task automatic push_exp(input int idx, input logic [WD-1:0] c, input logic e);
    exp_t x;
    x.idx = idx;
    x.cos = c;
    x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic raise(input int i, input logic [WD-1:0] ang);
    bus.req_angle[i*WD +: WD] = ang;
    bus.req_valid[i]          = 1'b1;
  endtask

  // One cycle; requesters drop valid after the edge that accepted them.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clock);
    acc = bus.req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && !hold[i]) bus.req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int max_cyc, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy || bus.req_valid != '0) && n < max_cyc) begin
      tick();
      n++;
    end
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok, busy_ok;
    int rs[N];
    int sc;

    bus.req_valid = '0;
    bus.req_angle = '0;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    do_reset(3);

    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_cos", bus.rsp_cos, 0);
    chk("rst_core_angle", bus.core_angle, 0);
`ifdef COS_SCHED_TIMEOUT_EN
    chk("rst_err", err, 0);
`endif
    @(posedge clock);
    #1;

    // single request, angle 0
    rs = ready_cnt;
    sc = rsp_cnt[0];
    push_exp(0, 24'd1024, 1'b0);
    raise(0, 24'd0);
    drain(100, "s1");
    chk("s1_ready_pulses", ready_cnt[0] - rs[0], 1);
    chk("s1_rsp_pulses", rsp_cnt[0] - sc, 1);

    // single request on requester 2, angle 1.0, with busy tracking
    push_exp(2, 24'd552, 1'b0);
    raise(2, 24'd1024);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clock);
      ok = bus.req_ready[2];
    end
    chk("s2_grant_seen", ok, 1);
    chk("s2_busy_at_grant", busy, 0);
    @(posedge clock);
    #1;
    bus.req_valid[2] = 1'b0;
    ok      = 1'b0;
    busy_ok = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clock);
      ok = bus.rsp_valid[2];
      if (!busy) busy_ok = 1'b0;
    end
    chk("s2_rsp_seen", ok, 1);
    chk("s2_busy_during_op", busy_ok, 1);
    @(negedge clock);
    chk("s2_busy_release", busy, 1);
    chk("s2_start_release", bus.core_start, 0);
    chk("s2_rsp_cos_hold", bus.rsp_cos, 552);
    @(negedge clock);
    chk("s2_busy_idle", busy, 0);
    @(posedge clock);
    #1;

    // all four at once after reset: order 0,1,2,3
    do_reset(2);
    rs = ready_cnt;
    push_exp(0, cos_ref(24'd100), 1'b0);
    push_exp(1, cos_ref(24'd400), 1'b0);
    push_exp(2, cos_ref(24'd800), 1'b0);
    push_exp(3, cos_ref(24'd1600), 1'b0);
    raise(0, 24'd100);
    raise(1, 24'd400);
    raise(2, 24'd800);
    raise(3, 24'd1600);
    drain(300, "s3");
    for (int i = 0; i < N; i++) chk($sformatf("s3_ready_pulses_%0d", i), ready_cnt[i] - rs[i], 1);
    chk("s3_core_angle_hold", bus.core_angle, 1600);

    // req1 held, req3 raised during the first operation: order 1,3,1
    rs = ready_cnt;
    hold[1] = 1'b1;
    push_exp(1, cos_ref(24'd300), 1'b0);
    push_exp(3, cos_ref(24'd700), 1'b0);
    push_exp(1, cos_ref(24'd300), 1'b0);
    raise(1, 24'd300);
    for (int n = 0; n < 50 && (ready_cnt[1] - rs[1]) < 1; n++) tick();
    chk("s4_first_grant", ready_cnt[1] - rs[1], 1);
    repeat (2) tick();
    raise(3, 24'd700);
    for (int n = 0; n < 100 && (ready_cnt[3] - rs[3]) < 1; n++) tick();
    chk("s4_req3_grant", ready_cnt[3] - rs[3], 1);
    hold[1] = 1'b0;
    drain(300, "s4");
    chk("s4_req1_grants", ready_cnt[1] - rs[1], 2);

    // reset while in WAIT_HI abandons the operation and clears the pointer
    raise(0, 24'd500);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clock);
      ok = bus.req_ready[0];
    end
    chk("s5_grant_seen", ok, 1);
    @(posedge clock);
    #1;
    bus.req_valid[0] = 1'b0;
    // START, two WAIT_LO cycles (stale ready), then WAIT_HI for CORE_LAT cycles
    repeat (5) @(negedge clock);
    chk("s5_in_wait_start", bus.core_start, 1);
    chk("s5_in_wait_ready", bus.core_ready, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("s5_core_start", bus.core_start, 0);
    chk("s5_busy", busy, 0);
    chk("s5_rsp_valid", bus.rsp_valid, 0);
    chk("s5_rsp_cos", bus.rsp_cos, 0);
    chk("s5_core_angle", bus.core_angle, 0);
    @(posedge clock);
    #1;
    push_exp(0, cos_ref(24'd50), 1'b0);
    push_exp(1, cos_ref(24'd60), 1'b0);
    raise(1, 24'd60);
    raise(0, 24'd50);
    drain(200, "s5");

`ifdef COS_SCHED_TIMEOUT_EN
    // core never answers: watchdog ends the operation with err
    core_dead = 1'b1;
    sc = start_cycles;
    push_exp(2, 24'd0, 1'b1);
    raise(2, 24'd200);
    drain(300, "s6");
    chk("s6_start_cycles", start_cycles - sc, TO + 1);
    core_dead = 1'b0;
`endif

    chk("ready_while_busy", busy_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
